instruction_fetch_unit: RTL and testbench

- Fetch-side initiator for the 1 KB byte-addressed, big-endian, combinational-read instruction memory.
- Drives the memory PC each cycle and captures the returned 32-bit word together with its PC into a small fetch queue.
- Presents queued instructions to decode through a valid/ready handshake.
- Handles control-flow redirects (taken beq/bne, etc.) by flushing the queue and reloading the PC.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 76 +++++++
 rtl/instruction_fetch_unit.sv | 77 +++++++
 tb/tb_instruction_fetch_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

    localparam int unsigned INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // One fetch-queue slot: the instruction word and the address it came from.
    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Force a redirect target onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries; flush empties it and wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t push_data_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    // Next-state for pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = PTR_ZERO;
            tail_d  = PTR_ZERO;
            count_d = CNT_ZERO;
        end else begin
            if (push_i) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            if (pop_i) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            count_d = count_q + (push_i ? CNT_ONE : CNT_ZERO) - (pop_i ? CNT_ONE : CNT_ZERO);
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= PTR_ZERO;
            tail_q  <= PTR_ZERO;
            count_q <= CNT_ZERO;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (rst_n && push_i && !flush_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch-side initiator: drives the PC, queues returned words, handles redirects.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC_DEFAULT,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned INST_W   = fetch_pkg::INST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:0]       pc,
    input  logic [INST_W-1:0] instOut,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [31:0]       out_pc,
    output logic              misalign_err
);
    import fetch_pkg::*;

    localparam int unsigned   CW       = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic [31:0]   pc_q, pc_d;
    logic          misalign_q, misalign_d;
    logic          push_s, pop_s;
    logic [CW-1:0] count_s;
    fetch_entry_t  wr_entry_s, head_s;

    // Handshake, push decision and next PC; redirect outranks fetching.
    always_comb begin
        pop_s      = out_valid & out_ready;
        push_s     = fetch_en & ~redirect_valid & ((count_s != FULL_CNT) | pop_s);
        misalign_d = redirect_valid & (redirect_pc[1:0] != 2'b00);
        wr_entry_s = '{pc: pc_q, inst: instOut};
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (push_s) begin
            pc_d = pc_q + PC_STEP;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and misalignment flag registers; reset overrides any redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .push_data_i (wr_entry_s),
        .head_o      (head_s),
        .count_o     (count_s)
    );

    assign pc           = pc_q;
    assign misalign_err = misalign_q;
    assign out_valid    = (count_s != CNT_ZERO);
    assign out_inst     = head_s.inst;
    assign out_pc       = head_s.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] instOut;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        misalign_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [256];

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .instOut        (instOut),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    assign instOut = mem[pc[9:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | (i << 2);
        mem[0]  = 32'h0244_43B3;   // div x7,x8,x4
        mem[1]  = 32'h0012_A203;   // load x4,1(x5)
        mem[11] = 32'h0012_8313;   // addi x6,x5,1

        rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        chk("reset_pc", pc, 32'h0);
        chk("reset_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_misalign", {31'b0, misalign_err}, 32'h0);

        // Streaming fetch with decode always ready
        rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        tick();
        chk("c1_valid", {31'b0, out_valid}, 32'h1);
        chk("c1_pc", out_pc, 32'h0);
        chk("c1_inst", out_inst, 32'h0244_43B3);
        chk("c1_fetchpc", pc, 32'h4);
        tick();
        chk("c2_pc", out_pc, 32'h4);
        chk("c2_inst", out_inst, 32'h0012_A203);
        chk("c2_fetchpc", pc, 32'h8);
        tick();
        chk("c3_pc", out_pc, 32'h8);
        chk("c3_inst", out_inst, 32'hC0DE_0008);
        chk("c3_fetchpc", pc, 32'hC);

        // Fresh start with decode stalled: queue fills then PC freezes
        rst_n = 1'b0; tick();
        rst_n = 1'b1; out_ready = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("full_pc", pc, 32'd16);
        chk("full_head", out_pc, 32'h0);
        tick();
        chk("full_pc_hold", pc, 32'd16);
        chk("full_valid", {31'b0, out_valid}, 32'h1);
        out_ready = 1'b1;
        tick();
        chk("full_pop_head", out_pc, 32'd4);
        chk("full_pop_pc", pc, 32'd20);
        out_ready = 1'b0;
        tick();
        chk("full_still", pc, 32'd20);

        // Drain one with fetch disabled: 3 entries left, PC holds
        fetch_en = 1'b0; out_ready = 1'b1;
        tick();
        chk("drain_head", out_pc, 32'd8);
        chk("drain_pc", pc, 32'd20);

        // Redirect to 36 with 3 entries queued
        fetch_en = 1'b1; out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'd36;
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid", {31'b0, out_valid}, 32'h0);
        chk("redir_pc", pc, 32'd36);
        chk("redir_misalign", {31'b0, misalign_err}, 32'h0);
        tick();
        chk("redir_head", out_pc, 32'd36);
        chk("redir_inst", out_inst, 32'hC0DE_0024);
        out_ready = 1'b1;
        tick();
        chk("redir_next", out_pc, 32'd40);

        // Misaligned redirect to 0x2E
        redirect_valid = 1'b1; redirect_pc = 32'h0000_002E;
        tick();
        redirect_valid = 1'b0;
        chk("mis_pc", pc, 32'h2C);
        chk("mis_err", {31'b0, misalign_err}, 32'h1);
        chk("mis_valid", {31'b0, out_valid}, 32'h0);
        tick();
        chk("mis_err_clr", {31'b0, misalign_err}, 32'h0);
        chk("mis_head", out_pc, 32'h2C);
        chk("mis_inst", out_inst, 32'h0012_8313);
        tick();
        chk("mis_next", out_pc, 32'h30);

        // Fill the queue, then reset together with a misaligned redirect
        out_ready = 1'b0;
        tick(); tick(); tick(); tick();
        chk("pre_rst_pc", pc, 32'd64);
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("mid_rst_misalign", {31'b0, misalign_err}, 32'h0);
        rst_n = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("post_rst_head", out_pc, 32'h0);
        chk("post_rst_inst", out_inst, 32'h0244_43B3);

        // fetch_en toggles 1,0,1
        fetch_en = 1'b0;
        tick();
        chk("fe0_valid", {31'b0, out_valid}, 32'h0);
        chk("fe0_pc", pc, 32'h4);
        fetch_en = 1'b1;
        tick();
        chk("fe1_valid", {31'b0, out_valid}, 32'h1);
        chk("fe1_head", out_pc, 32'h4);
        tick();
        chk("fe1_next", out_pc, 32'h8);

        // Back-to-back redirects: last one wins
        redirect_valid = 1'b1; redirect_pc = 32'd100;
        tick();
        chk("b2b_pc1", pc, 32'd100);
        redirect_pc = 32'd200;
        tick();
        redirect_valid = 1'b0;
        chk("b2b_pc2", pc, 32'd200);
        chk("b2b_valid", {31'b0, out_valid}, 32'h0);
        tick();
        chk("b2b_head", out_pc, 32'd200);
        chk("b2b_inst", out_inst, 32'hC0DE_00C8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
